load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: runs datapath loads/stores as valid/ready data-memory bus transactions with stall, extension and fault reporting
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t      state, state_next;
    logic [7:0]  counter;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        load_q;
    logic        f3_ok, aligned, valid_req, bad_req, timed_out;
    logic [31:0] wdata_n, byte_v, half_v, load_val;
    logic [3:0]  wstrb_n;
    // request legality, store lane steering and load extraction
    always_comb begin
        f3_ok     = mem_read ? funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} : funct3 inside {3'd0, 3'd1, 3'd2};
        aligned   = funct3[1:0] == 2'b01 ? !address[0] : funct3[1:0] == 2'b10 ? address[1:0] == 2'b00 : 1'b1;
        valid_req = (mem_read ^ mem_write) && f3_ok && aligned;
        bad_req   = (mem_read || mem_write) && !valid_req;
        timed_out = counter == 8'(TIMEOUT - 1);
        wdata_n   = funct3[1:0] == 2'b00 ? {4{write_data[7:0]}} : funct3[1:0] == 2'b01 ? {2{write_data[15:0]}} : write_data;
        wstrb_n   = !mem_write ? 4'b0000 : funct3[1:0] == 2'b00 ? 4'b0001 << address[1:0] :
                    funct3[1:0] == 2'b01 ? 4'b0011 << address[1:0] : 4'b1111;
        byte_v    = bus_rdata >> {off_q, 3'b000};
        half_v    = bus_rdata >> {off_q[1], 4'b0000};
        load_val  = f3_q == 3'd0 ? {{24{byte_v[7]}}, byte_v[7:0]} :
                    f3_q == 3'd1 ? {{16{half_v[15]}}, half_v[15:0]} :
                    f3_q == 3'd4 ? {24'd0, byte_v[7:0]} :
                    f3_q == 3'd5 ? {16'd0, half_v[15:0]} : bus_rdata;
    end
    // stall covers the accepting IDLE cycle and every BUS cycle; reset forces it low
    always_comb begin
        stall = !reset && ((state == IDLE && valid_req) || state == BUS);
    end
    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    // next state: accept, wait for ready or timeout, then one commit cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = valid_req ? BUS : IDLE;
            BUS:     state_next = (bus_ready || timed_out) ? DONE : BUS;
            default: state_next = IDLE;
        endcase
    end
    // bus request, wait counter, load result and fault pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter      <= '0;
            f3_q         <= '0;
            off_q        <= '0;
            load_q       <= 1'b0;
            read_data    <= '0;
            access_fault <= 1'b0;
            bus_valid    <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_wstrb    <= '0;
        end else begin
            access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_req) begin
                        bus_valid <= 1'b1;
                        bus_addr  <= {address[31:2], 2'b00};
                        bus_wdata <= wdata_n;
                        bus_wstrb <= wstrb_n;
                        f3_q      <= funct3;
                        off_q     <= address[1:0];
                        load_q    <= mem_read;
                        counter   <= '0;
                    end else if (bad_req) begin
                        access_fault <= 1'b1;
                    end
                end
                BUS: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if (load_q) read_data <= load_val;
                    end else if (timed_out) begin
                        bus_valid    <= 1'b0;
                        access_fault <= 1'b1;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench for load_store_unit
module tb_load_store_unit;
    localparam int TO = 4;
    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          waits;
        int          exp_bus;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic        exp_fault;
        logic        upd;
        logic [31:0] exp_rd;
    } vec_t;
    logic        clock = 1'b0, reset = 1'b1, mem_read = 1'b0, mem_write = 1'b0, bus_ready = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = '0, write_data = '0, bus_rdata = '0;
    logic [31:0] read_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        stall, access_fault, bus_valid;
    int          checks = 0, errors = 0;
    logic [31:0] rd_model = '0;
    logic [31:0] sb_q[$];
    vec_t        vt[15];
    load_store_unit #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .address(address), .write_data(write_data), .read_data(read_data),
        .stall(stall), .access_fault(access_fault), .bus_valid(bus_valid), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );
    always #5 clock = ~clock;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic run(input vec_t v);
        int n;
        logic [31:0] e;
        @(posedge clock); #1;
        mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; address = v.addr;
        write_data = v.wd; bus_rdata = v.rdata; bus_ready = 1'b0;
        sb_q.push_back(v.upd ? v.exp_rd : rd_model);
        @(negedge clock);
        chk("idle_stall", 32'(stall), 32'(v.exp_bus != 0));
        chk("idle_valid", 32'(bus_valid), 32'd0);
        @(posedge clock); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        n = 0;
        if (v.exp_bus != 0) begin
            for (int c = 0; c < 20; c++) begin
                bus_ready = (n == v.waits);
                @(negedge clock);
                if (!stall) break;
                chk("bus_valid", 32'(bus_valid), 32'd1);
                chk("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
                chk("bus_wstrb", 32'(bus_wstrb), 32'(v.exp_strb));
                if (v.wr) chk("bus_wdata", bus_wdata, v.exp_wdata);
                n++;
                @(posedge clock); #1;
            end
        end else begin
            @(negedge clock);
        end
        bus_ready = 1'b0;
        chk("bus_cycles", 32'(n), 32'(v.exp_bus));
        chk("fault", 32'(access_fault), 32'(v.exp_fault));
        chk("done_valid", 32'(bus_valid), 32'd0);
        chk("done_stall", 32'(stall), 32'd0);
        e = sb_q.pop_front();
        chk("read_data", read_data, e);
        rd_model = e;
        @(negedge clock);
        chk("fault_once", 32'(access_fault), 32'd0);
        chk("idle_after", 32'(stall), 32'd0);
    endtask
    initial begin
        vt[0]  = '{1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2, 3, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[1]  = '{1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 32'h80112233, 0, 1, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80};
        vt[2]  = '{1'b1, 1'b0, 3'd4, 32'h203, 32'h0, 32'h80112233, 1, 2, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h00000080};
        vt[3]  = '{1'b1, 1'b0, 3'd1, 32'h202, 32'h0, 32'h80112233, 1, 2, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFF8011};
        vt[4]  = '{1'b1, 1'b0, 3'd5, 32'h200, 32'h0, 32'h1234F678, 0, 1, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0000F678};
        vt[5]  = '{1'b1, 1'b0, 3'd0, 32'h000, 32'h0, 32'hAABBCC7F, 0, 1, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0000007F};
        vt[6]  = '{1'b0, 1'b1, 3'd1, 32'h302, 32'h0000ABCD, 32'h0, 0, 1, 4'b1100, 32'hABCDABCD, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 1'b1, 3'd0, 32'h301, 32'h123456A5, 32'h0, 2, 3, 4'b0010, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h11111111, 0, 0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 1'b1, 3'd2, 32'h100, 32'h0, 32'h11111111, 0, 0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[10] = '{1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 32'h11111111, 0, 0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[11] = '{1'b0, 1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[12] = '{1'b0, 1'b1, 3'd1, 32'h301, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[13] = '{1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 32'h55555555, 255, TO, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[14] = '{1'b0, 1'b1, 3'd2, 32'h040, 32'hCAFEF00D, 32'h0, 1, 2, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        repeat (2) @(negedge clock);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fault", 32'(access_fault), 32'd0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wstrb", 32'(bus_wstrb), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) run(vt[i]);
        @(posedge clock); #1;
        mem_read = 1'b1; funct3 = 3'd2; address = 32'h80; bus_ready = 1'b0;
        @(posedge clock); #1;
        mem_read = 1'b0;
        @(posedge clock); #1;
        chk("pre_rst_valid", 32'(bus_valid), 32'd1);
        chk("pre_rst_stall", 32'(stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus_valid), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rd_model = '0;
        chk("post_rst_read_data", read_data, 32'h0);
        run(vt[14]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
